inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Initiator side of the instruction-ROM interface: owns the PC, drives rom_ce/rom_addr,
//  samples the combinational rom_inst and registers {pc, inst} into the IF/ID stage.
//  Handles pipeline stalls, branch redirects (branch arrives from ID), flush redirects (CP0)
//  and misaligned fetch detection. Sits between ctrl/id and the instruction ROM.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  PC_STEP   4              sequential PC increment (bytes)
// PORTS
//  clk            in   1   single clock, all state updates on posedge
//  rst            in   1   synchronous reset, active low (0 = reset)
//  stall          in   6   ctrl stall bus; stall[0]=PC hold, stall[1]=IF hold, stall[2]=ID hold
//  flush          in   1   exception/eret redirect, highest priority
//  flush_pc       in   32  redirect target when flush=1
//  branch_flag_i  in   1   taken branch/jump resolved in ID this cycle
//  branch_addr_i  in   32  branch/jump target
//  rom_ce         out  1   ROM chip enable (`ChipEnable/`ChipDisable)
//  rom_addr       out  32  byte address to ROM (= pc)
//  rom_inst       in   32  instruction returned combinationally by ROM
//  id_pc          out  32  registered PC of instruction in ID
//  id_inst        out  32  registered instruction in ID
//  id_adel        out  1   registered: instruction in ID came from a misaligned fetch
// BEHAVIOUR
//  Reset (rst==0 at posedge): pc=RESET_PC, ce_r=0, state=IDLE, br_pend=0, br_tgt=0,
//   id_pc=0, id_inst=`ZeroWord, id_adel=0. Reset mid-operation discards any pending branch.
//  FSM: IDLE -> RUN on first clock with rst==1 (ce_r<=1, pc stays RESET_PC); RUN stays RUN.
//  rom_addr = pc (comb). rom_ce = ce_r & (pc[1:0]==2'b00); misaligned pc never enables ROM.
//  ROM latency 0: rom_inst is valid in the same cycle as rom_addr.
//  PC next-value priority (RUN only):
//   1 flush             -> pc<=flush_pc; br_pend<=0
//   2 stall[0]          -> pc holds; if branch_flag_i: br_pend<=1, br_tgt<=branch_addr_i
//   3 br_pend           -> pc<=br_tgt; br_pend<=0
//   4 branch_flag_i     -> pc<=branch_addr_i
//   5 otherwise         -> pc<=pc+PC_STEP (mod 2^32; 32'hFFFF_FFFC wraps to 0)
//  branch_flag_i with flush in same cycle: flush wins, branch dropped.
//  Branch is taken once: a 1-cycle branch_flag_i under stall must not be lost (br_pend);
//   br_pend set while branch_flag_i asserts again: newest target overwrites br_tgt.
//  Delay slot: the instruction fetched in the cycle the branch resolves enters ID normally.
//  IF/ID register priority:
//   1 flush                    -> id_pc=0, id_inst=`ZeroWord, id_adel=0 (bubble)
//   2 stall[1] & !stall[2]     -> bubble (same zero values)
//   3 !stall[1]                -> id_pc=pc, id_inst=(rom_ce ? rom_inst : `ZeroWord),
//                                 id_adel=ce_r & (pc[1:0]!=0)
//   4 otherwise                -> hold
//  In IDLE the IF/ID register loads bubbles; no instruction reaches ID before RUN.
// STRUCTURE
//  defines.v: `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable/`ChipDisable (existing);
//   add `IfStIdle/`IfStRun state codes and `ResetPC default.
//  One sub-module: if_id_reg (IF/ID pipeline register with flush/stall/bubble rules above);
//   PC, FSM and branch-pending latch live in inst_fetch.
// TESTING
//  T1 reset 3 cycles then release, ROM[i]=i+1 -> rom_ce 0 in cycle 1, pc=0 for 2 cycles,
//     then id_inst=1,2,3.. with id_pc=0,4,8..
//  T2 branch_flag_i=1, target 32'h100, no stall -> next pc=32'h100; delay slot inst enters ID
//     first, then ROM[0x40] with id_pc=32'h100.
//  T3 stall=6'b000011 for 3 cycles, 1-cycle branch to 32'h200 in first stalled cycle ->
//     pc held; after stall release pc=32'h200 exactly once, then 32'h204.
//  T4 flush=1, flush_pc=32'h4000_0380 with simultaneous branch to 32'h80 -> pc=32'h4000_0380,
//     id_inst=0, br_pend=0.
//  T5 branch to 32'h102 -> rom_ce=0, next-cycle id_adel=1, id_inst=0, id_pc=32'h102.
//  T6 pc=32'hFFFF_FFFC free-running -> next pc=0; rst=0 while br_pend=1 -> pc=RESET_PC,
//     br_pend=0, outputs at reset values.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage: bus widths, ROM enable
// levels, fetch FSM state codes and the IF/ID payload record.
package inst_fetch_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned STALL_W     = 6;

   localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
   localparam logic                   CHIP_ENABLE      = 1'b1;
   localparam logic                   CHIP_DISABLE     = 1'b0;
   localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned            PC_STEP_DEFAULT  = 4;

   localparam logic [0:0] IF_ST_IDLE = 1'b0;
   localparam logic [0:0] IF_ST_RUN  = 1'b1;

   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
      logic                   adel;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{pc: '0, inst: ZERO_WORD, adel: 1'b0};

   function automatic logic is_word_aligned(input logic [INST_ADDR_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: captures {pc, inst, adel} from fetch, inserting bubbles on
// flush, before the fetch FSM runs, and when IF stalls while ID keeps moving.
module if_id_reg
   import inst_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_fetch_run,
   input  logic                   i_stall_if,
   input  logic                   i_stall_id,
   input  logic [INST_ADDR_W-1:0] i_if_pc,
   input  logic [INST_W-1:0]      i_if_inst,
   input  logic                   i_if_adel,
   output logic [INST_ADDR_W-1:0] o_id_pc,
   output logic [INST_W-1:0]      o_id_inst,
   output logic                   o_id_adel
);

   if_id_t r_id;
   if_id_t w_if;

   assign w_if = '{pc: i_if_pc, inst: i_if_inst, adel: i_if_adel};

   // NOTE: state is written with <= so every flop samples pre-edge values; blocking here
   // would let downstream logic in the same block see the new value within one edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_id <= IF_ID_BUBBLE;
      end else if (i_flush || !i_fetch_run) begin
         r_id <= IF_ID_BUBBLE;
      end else if (i_stall_if && !i_stall_id) begin
         r_id <= IF_ID_BUBBLE;
      end else if (!i_stall_if) begin
         r_id <= w_if;
      end
      // Both stages stalled: register holds.
   end

   assign o_id_pc   = r_id.pc;
   assign o_id_inst = r_id.inst;
   assign o_id_adel = r_id.adel;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM request, remembers branches that
// resolve while the PC is stalled, and feeds the IF/ID register.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned            PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_W-1:0]     stall,
   input  logic                   flush,
   input  logic [INST_ADDR_W-1:0] flush_pc,
   input  logic                   branch_flag_i,
   input  logic [INST_ADDR_W-1:0] branch_addr_i,
   output logic                   rom_ce,
   output logic [INST_ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0]      rom_inst,
   output logic [INST_ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0]      id_inst,
   output logic                   id_adel
);

   localparam logic [INST_ADDR_W-1:0] PC_INC = INST_ADDR_W'(PC_STEP);

   logic [0:0]             r_state;
   logic [INST_ADDR_W-1:0] r_pc;
   logic                   r_ce;
   logic                   r_br_pend;
   logic [INST_ADDR_W-1:0] r_br_tgt;

   logic                   w_aligned;
   logic                   w_fetch_run;
   logic [INST_W-1:0]      w_if_inst;
   logic                   w_if_adel;
   logic                   w_unused_stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IF_ST_IDLE;
         r_pc      <= RESET_PC;
         r_ce      <= CHIP_DISABLE;
         r_br_pend <= 1'b0;
         r_br_tgt  <= '0;
      end else if (r_state == IF_ST_IDLE) begin
         r_state <= IF_ST_RUN;
         r_ce    <= CHIP_ENABLE;
      end else if (flush) begin
         r_pc      <= flush_pc;
         r_br_pend <= 1'b0;
      end else if (stall[0]) begin
         // A one-cycle branch seen while the PC is frozen is parked until the stall lifts.
         if (branch_flag_i) begin
            r_br_pend <= 1'b1;
            r_br_tgt  <= branch_addr_i;
         end
      end else if (r_br_pend) begin
         r_pc      <= r_br_tgt;
         r_br_pend <= 1'b0;
      end else if (branch_flag_i) begin
         r_pc <= branch_addr_i;
      end else begin
         r_pc <= r_pc + PC_INC;
      end
   end

   assign w_aligned   = is_word_aligned(r_pc);
   assign w_fetch_run = (r_state == IF_ST_RUN);

   assign rom_addr  = r_pc;
   assign rom_ce    = r_ce & w_aligned;
   assign w_if_inst = rom_ce ? rom_inst : ZERO_WORD;
   assign w_if_adel = r_ce & ~w_aligned;

   // Upper stall bits belong to later pipeline stages.
   assign w_unused_stall = ^stall[STALL_W-1:3];

   if_id_reg u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (flush),
      .i_fetch_run (w_fetch_run),
      .i_stall_if  (stall[1]),
      .i_stall_id  (stall[2]),
      .i_if_pc     (r_pc),
      .i_if_inst   (w_if_inst),
      .i_if_adel   (w_if_adel),
      .o_id_pc     (id_pc),
      .o_id_inst   (id_inst),
      .o_id_adel   (id_adel)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the driver queues the expected post-edge view for every
// cycle it drives, and a monitor pops and compares one entry after each clock edge.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag_i;
   logic [31:0] branch_addr_i;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_adel;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        ce;
      logic [31:0] ipc;
      logic [31:0] iinst;
      logic        adel;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [5:0] S0  = 6'b000000;
   localparam logic [5:0] S3  = 6'b000011;
   localparam logic [5:0] S7  = 6'b000111;

   always #5 clk = ~clk;

   // ROM holds word i = i+1 at byte address 4*i, answered combinationally.
   assign rom_inst = {2'b00, rom_addr[31:2]} + 32'd1;

   inst_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .branch_flag_i (branch_flag_i),
      .branch_addr_i (branch_addr_i),
      .rom_ce        (rom_ce),
      .rom_addr      (rom_addr),
      .rom_inst      (rom_inst),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_adel       (id_adel)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [5:0] st, input logic fl,
                       input logic [31:0] fpc, input logic br, input logic [31:0] ba,
                       input string nm, input logic [31:0] e_addr, input logic e_ce,
                       input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_adel);
      exp_t e;
      @(negedge clk);
      rst           = r;
      stall         = st;
      flush         = fl;
      flush_pc      = fpc;
      branch_flag_i = br;
      branch_addr_i = ba;
      e.name  = nm;
      e.addr  = e_addr;
      e.ce    = e_ce;
      e.ipc   = e_pc;
      e.iinst = e_inst;
      e.adel  = e_adel;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".rom_addr"}, rom_addr, e.addr);
            check({e.name, ".rom_ce"},   {31'd0, rom_ce}, {31'd0, e.ce});
            check({e.name, ".id_pc"},    id_pc, e.ipc);
            check({e.name, ".id_inst"},  id_inst, e.iinst);
            check({e.name, ".id_adel"},  {31'd0, id_adel}, {31'd0, e.adel});
         end
      end
   end

   initial begin : driver
      rst = 1'b0; stall = S0; flush = 1'b0; flush_pc = '0;
      branch_flag_i = 1'b0; branch_addr_i = '0;

      // T1: reset, start-up and sequential fetch
      step(0, S0, 0, 0, 0, 0, "rst0", 32'h0, 0, 32'h0, 32'h0, 0);
      step(0, S0, 0, 0, 0, 0, "rst1", 32'h0, 0, 32'h0, 32'h0, 0);
      step(0, S0, 0, 0, 0, 0, "rst2", 32'h0, 0, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "idle2run", 32'h0, 1, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "seq0", 32'h4, 1, 32'h0, 32'h1, 0);
      step(1, S0, 0, 0, 0, 0, "seq1", 32'h8, 1, 32'h4, 32'h2, 0);
      step(1, S0, 0, 0, 0, 0, "seq2", 32'hC, 1, 32'h8, 32'h3, 0);
      // T2: taken branch, delay slot enters ID first
      step(1, S0, 0, 0, 1, 32'h100, "br_slot", 32'h100, 1, 32'hC, 32'h4, 0);
      step(1, S0, 0, 0, 0, 0, "br_tgt", 32'h104, 1, 32'h100, 32'h41, 0);
      // T3: one-cycle branch under stall is parked and taken once
      step(1, S3, 0, 0, 1, 32'h200, "stl_br", 32'h104, 1, 32'h0, 32'h0, 0);
      step(1, S3, 0, 0, 0, 0, "stl1", 32'h104, 1, 32'h0, 32'h0, 0);
      step(1, S3, 0, 0, 0, 0, "stl2", 32'h104, 1, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "pend_go", 32'h200, 1, 32'h104, 32'h42, 0);
      step(1, S0, 0, 0, 0, 0, "pend_nxt", 32'h204, 1, 32'h200, 32'h81, 0);
      step(1, S0, 0, 0, 0, 0, "pend_seq", 32'h208, 1, 32'h204, 32'h82, 0);
      // IF and ID both stalled: IF/ID holds
      step(1, S7, 0, 0, 0, 0, "hold", 32'h208, 1, 32'h204, 32'h82, 0);
      step(1, S0, 0, 0, 0, 0, "unhold", 32'h20C, 1, 32'h208, 32'h83, 0);
      // Newer branch under stall overwrites the parked target
      step(1, S3, 0, 0, 1, 32'h300, "ovr0", 32'h20C, 1, 32'h0, 32'h0, 0);
      step(1, S3, 0, 0, 1, 32'h400, "ovr1", 32'h20C, 1, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "ovr_go", 32'h400, 1, 32'h20C, 32'h84, 0);
      step(1, S0, 0, 0, 0, 0, "ovr_nxt", 32'h404, 1, 32'h400, 32'h101, 0);
      // T4: flush beats a simultaneous branch
      step(1, S0, 1, 32'h4000_0380, 1, 32'h80, "flush",
           32'h4000_0380, 1, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "fl_nxt", 32'h4000_0384, 1, 32'h4000_0380, 32'h1000_00E1, 0);
      // Flush also discards a parked branch
      step(1, S3, 0, 0, 1, 32'h500, "fl_park", 32'h4000_0384, 1, 32'h0, 32'h0, 0);
      step(1, S3, 1, 32'h600, 0, 0, "fl_stl", 32'h600, 1, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "fl_clr", 32'h604, 1, 32'h600, 32'h181, 0);
      // T5: misaligned fetch
      step(1, S0, 0, 0, 1, 32'h102, "mis_br", 32'h102, 0, 32'h604, 32'h182, 0);
      step(1, S0, 0, 0, 0, 0, "mis_id", 32'h106, 0, 32'h102, 32'h0, 1);
      step(1, S0, 0, 0, 1, 32'h1000, "mis_out", 32'h1000, 1, 32'h106, 32'h0, 1);
      step(1, S0, 0, 0, 0, 0, "realign", 32'h1004, 1, 32'h1000, 32'h401, 0);
      // T6: PC wrap at top of address space
      step(1, S0, 0, 0, 1, 32'hFFFF_FFF8, "top_br", 32'hFFFF_FFF8, 1, 32'h1004, 32'h402, 0);
      step(1, S0, 0, 0, 0, 0, "top0", 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h3FFF_FFFF, 0);
      step(1, S0, 0, 0, 0, 0, "wrap", 32'h0, 1, 32'hFFFF_FFFC, 32'h4000_0000, 0);
      step(1, S0, 0, 0, 0, 0, "wrap_nxt", 32'h4, 1, 32'h0, 32'h1, 0);
      // Reset while a branch is parked discards it
      step(1, S3, 0, 0, 1, 32'h700, "rp_park", 32'h4, 1, 32'h0, 32'h0, 0);
      step(0, S0, 0, 0, 0, 0, "rp_rst", 32'h0, 0, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "rp_run", 32'h0, 1, 32'h0, 32'h0, 0);
      step(1, S0, 0, 0, 0, 0, "rp_seq", 32'h4, 1, 32'h0, 32'h1, 0);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
